// File: rtl/model_stream_pkg.sv
// Shared types and helpers for the conv-model stream driver.
package model_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_STREAM,
    ST_FIN
  } state_t;

  localparam int KERNEL_BYTE_MSB = 7;
  localparam int WORD_W          = 32;

  function automatic logic [WORD_W-1:0] sext8_to_32(input logic [KERNEL_BYTE_MSB:0] b);
    return {{(WORD_W-KERNEL_BYTE_MSB-1){b[KERNEL_BYTE_MSB]}}, b};
  endfunction

endpackage

// File: rtl/pix_prefetch_fifo.sv
// Two-entry pixel prefetch FIFO with synchronous flush; head is visible on o_data.
module pix_prefetch_fifo #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  // NOTE: storage is not reset; validity is carried entirely by r_count and the pointers.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= !r_wr_ptr;
      if (i_pop)  r_rd_ptr <= !r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/model_stream_driver.sv
// Feeds the conv model: optional parameter image from ROM, then one or more
// pixel frames from pixel memory through a two-entry prefetch FIFO.
module model_stream_driver
  import model_stream_pkg::*;
#(
  parameter int IN_CHANNEL   = 3,
  parameter int PIXELS       = 65536,
  parameter int NUM_PARAMS   = 449,
  parameter int KERNEL_WORDS = 432,
  parameter int PARAM_BASE   = 0,
  parameter int PIX_AW       = 16,
  parameter int PRM_AW       = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    reload_params,
  input  logic [7:0]              num_frames,
  input  logic                    abort,
  output logic                    prm_rd_en,
  output logic [PRM_AW-1:0]       prm_rd_addr,
  input  logic [31:0]             prm_rd_data,
  output logic                    pix_rd_en,
  output logic [PIX_AW-1:0]       pix_rd_addr,
  input  logic [8*IN_CHANNEL-1:0] pix_rd_data,
  output logic                    weight_wr_en,
  output logic [31:0]             weight_wr_addr,
  output logic [31:0]             weight_wr_data,
  output logic [8*IN_CHANNEL-1:0] i_data,
  output logic                    i_valid,
  input  logic                    fifo_rd_en,
  input  logic                    fifo_almost_full,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              frame_idx
);

  localparam int                PIX_W    = 8*IN_CHANNEL;
  localparam logic [PIX_AW-1:0] LAST_PIX = PIX_AW'(PIXELS-1);
  localparam logic [PRM_AW-1:0] LAST_PRM = PRM_AW'(NUM_PARAMS-1);

  state_t              r_state, w_next;
  logic [PRM_AW-1:0]   r_prm_cnt, r_wr_idx;
  logic                r_prm_pend, r_gap_cnt;
  logic [PIX_AW-1:0]   r_fetch_addr, r_pop_addr;
  logic [7:0]          r_fetch_frame, r_frame_idx, r_last_frame;
  logic                r_fetch_done, r_pix_pend, r_final;
  logic                r_i_valid;
  logic [PIX_W-1:0]    r_i_data;

  logic [PIX_W-1:0]    w_fifo_data;
  logic [1:0]          w_fifo_count;
  logic [2:0]          w_occ;
  logic                w_start, w_prm_rd, w_pix_rd, w_pop, w_flush;

  assign w_start  = (r_state == ST_IDLE) && start && !abort;
  assign w_prm_rd = (r_state == ST_LOAD);
  assign w_flush  = !rst_n || abort;
  assign w_pop    = (r_state == ST_STREAM) && fifo_rd_en && !fifo_almost_full
                    && (w_fifo_count != 2'd0);
  // Occupancy counts the slot freed by this cycle's pop, so a pop and a read overlap at full rate.
  assign w_occ    = 3'(w_fifo_count) + 3'(r_pix_pend) - 3'(w_pop);
  assign w_pix_rd = (r_state == ST_STREAM) && !r_fetch_done && (w_occ < 3'd2);

  pix_prefetch_fifo #(.W(PIX_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_push  (r_pix_pend),
    .i_pop   (w_pop),
    .i_data  (pix_rd_data),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next takes a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = reload_params ? ST_LOAD : ST_STREAM;
      ST_LOAD:   if (r_prm_cnt == LAST_PRM) w_next = ST_GAP;
      ST_GAP:    if (r_gap_cnt) w_next = ST_STREAM;
      ST_STREAM: if (r_final) w_next = ST_FIN;
      ST_FIN:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    if (abort) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      r_prm_cnt     <= '0;
      r_wr_idx      <= '0;
      r_prm_pend    <= 1'b0;
      r_gap_cnt     <= 1'b0;
      r_fetch_addr  <= '0;
      r_pop_addr    <= '0;
      r_fetch_frame <= '0;
      r_last_frame  <= '0;
      r_fetch_done  <= 1'b0;
      r_pix_pend    <= 1'b0;
      r_final       <= 1'b0;
      r_i_valid     <= 1'b0;
      if (!rst_n) begin
        r_frame_idx <= '0;
        r_i_data    <= '0;
      end
    end else begin
      r_prm_pend <= w_prm_rd;
      r_wr_idx   <= r_prm_cnt;
      r_pix_pend <= w_pix_rd;
      r_i_valid  <= w_pop;
      if (w_pop) r_i_data <= w_fifo_data;

      if (w_start) begin
        r_prm_cnt     <= '0;
        r_gap_cnt     <= 1'b0;
        r_fetch_addr  <= '0;
        r_fetch_frame <= '0;
        r_fetch_done  <= 1'b0;
        r_pop_addr    <= '0;
        r_frame_idx   <= '0;
        r_final       <= 1'b0;
        r_last_frame  <= (num_frames == 8'd0) ? 8'd0 : num_frames - 8'd1;
      end

      if (w_prm_rd) r_prm_cnt <= r_prm_cnt + PRM_AW'(1);
      if (r_state == ST_GAP) r_gap_cnt <= 1'b1;

      if (w_pix_rd) begin
        if (r_fetch_addr == LAST_PIX) begin
          r_fetch_addr <= '0;
          if (r_fetch_frame == r_last_frame) r_fetch_done  <= 1'b1;
          else                               r_fetch_frame <= r_fetch_frame + 8'd1;
        end else begin
          r_fetch_addr <= r_fetch_addr + PIX_AW'(1);
        end
      end

      if (w_pop) begin
        if (r_pop_addr == LAST_PIX) begin
          r_pop_addr <= '0;
          if (r_frame_idx == r_last_frame) r_final     <= 1'b1;
          else                             r_frame_idx <= r_frame_idx + 8'd1;
        end else begin
          r_pop_addr <= r_pop_addr + PIX_AW'(1);
        end
      end
    end
  end

  assign prm_rd_en      = w_prm_rd;
  assign prm_rd_addr    = w_prm_rd ? r_prm_cnt : '0;
  assign pix_rd_en      = w_pix_rd;
  assign pix_rd_addr    = w_pix_rd ? r_fetch_addr : '0;
  assign weight_wr_en   = r_prm_pend;
  assign weight_wr_addr = r_prm_pend ? WORD_W'(PARAM_BASE) + WORD_W'(r_wr_idx) : '0;
  assign weight_wr_data = !r_prm_pend ? '0 :
                          (WORD_W'(r_wr_idx) < WORD_W'(KERNEL_WORDS))
                            ? sext8_to_32(prm_rd_data[KERNEL_BYTE_MSB:0])
                            : prm_rd_data;
  assign i_data         = r_i_data;
  assign i_valid        = r_i_valid;
  assign busy           = (r_state != ST_IDLE);
  assign done           = (r_state == ST_FIN);
  assign frame_idx      = r_frame_idx;

endmodule

// File: tb/tb_model_stream_driver.sv
// Scoreboard bench for model_stream_driver: expected weight writes and pixels are
// queued when a run is started and popped as the DUT emits them.
module tb_model_stream_driver;

  localparam int IN_CHANNEL   = 3;
  localparam int PIXELS       = 16;
  localparam int NUM_PARAMS   = 449;
  localparam int KERNEL_WORDS = 432;
  localparam int PARAM_BASE   = 0;
  localparam int PIX_AW       = 4;
  localparam int PRM_AW       = 10;
  localparam int PIX_W        = 8*IN_CHANNEL;

  logic              clk = 1'b0;
  logic              rst_n, start, reload_params, abort;
  logic [7:0]        num_frames;
  logic              prm_rd_en, pix_rd_en, weight_wr_en, i_valid;
  logic [PRM_AW-1:0] prm_rd_addr;
  logic [PIX_AW-1:0] pix_rd_addr;
  logic [31:0]       prm_rd_data = '0;
  logic [PIX_W-1:0]  pix_rd_data = '0;
  logic [31:0]       weight_wr_addr, weight_wr_data;
  logic [PIX_W-1:0]  i_data;
  logic              fifo_rd_en, fifo_almost_full, busy, done;
  logic [7:0]        frame_idx;

  model_stream_driver #(
    .IN_CHANNEL(IN_CHANNEL), .PIXELS(PIXELS), .NUM_PARAMS(NUM_PARAMS),
    .KERNEL_WORDS(KERNEL_WORDS), .PARAM_BASE(PARAM_BASE),
    .PIX_AW(PIX_AW), .PRM_AW(PRM_AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reload_params(reload_params),
    .num_frames(num_frames), .abort(abort),
    .prm_rd_en(prm_rd_en), .prm_rd_addr(prm_rd_addr), .prm_rd_data(prm_rd_data),
    .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
    .weight_wr_en(weight_wr_en), .weight_wr_addr(weight_wr_addr),
    .weight_wr_data(weight_wr_data), .i_data(i_data), .i_valid(i_valid),
    .fifo_rd_en(fifo_rd_en), .fifo_almost_full(fifo_almost_full),
    .busy(busy), .done(done), .frame_idx(frame_idx)
  );

  always #5 clk = ~clk;

  logic [31:0]      prm_mem [1<<PRM_AW];
  logic [PIX_W-1:0] pix_mem [PIXELS];

  always @(posedge clk) begin
    if (prm_rd_en) prm_rd_data <= prm_mem[prm_rd_addr];
    if (pix_rd_en) pix_rd_data <= pix_mem[pix_rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [PIX_W-1:0] pq [$];
  logic [63:0]      wq [$];
  logic [31:0]      wr_seen [NUM_PARAMS];
  int               n_pulse, t_first, t_last, n_done, n_wr, t_start;
  logic [7:0]       max_frame;
  bit               exp_done, prev_blocked, de;
  logic [PIX_W-1:0] pe;
  logic [63:0]      we;

  initial begin
    n_pulse = 0; t_first = 0; t_last = 0; n_done = 0; n_wr = 0; t_start = 0;
    max_frame = '0; exp_done = 0; prev_blocked = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      de       = exp_done;
      exp_done = 0;
      if (done) n_done++;
      if (done || de) check("done_timing", done, de);
      if (prev_blocked) check("bp_no_valid", i_valid, 0);
      prev_blocked = !fifo_rd_en || fifo_almost_full;
      if (i_valid) begin
        if (pq.size() == 0) check("pix_unexpected", 1, 0);
        else begin
          pe = pq.pop_front();
          check("pix_data", i_data, pe);
          if (n_pulse == 0) t_first = cyc;
          t_last = cyc;
          n_pulse++;
          if (pq.size() == 0) exp_done = 1;
        end
      end
      if (weight_wr_en) begin
        if (wq.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          we = wq.pop_front();
          check("wr_addr_data", {weight_wr_addr, weight_wr_data}, we);
          n_wr++;
          if (weight_wr_addr < NUM_PARAMS) wr_seen[weight_wr_addr[8:0]] = weight_wr_data;
        end
      end
      if (frame_idx > max_frame) max_frame = frame_idx;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_run(input bit reload, input logic [7:0] frames);
    int nf;
    logic [31:0] d;
    nf = (frames == 8'd0) ? 1 : int'(frames);
    if (reload) begin
      for (int k = 0; k < NUM_PARAMS; k++) begin
        d = prm_mem[k];
        if (k < KERNEL_WORDS) d = {{24{d[7]}}, d[7:0]};
        wq.push_back({32'(PARAM_BASE + k), d});
      end
    end
    for (int f = 0; f < nf; f++)
      for (int p = 0; p < PIXELS; p++) pq.push_back(pix_mem[p]);
    n_pulse = 0; n_wr = 0; max_frame = '0;
    reload_params = reload;
    num_frames    = frames;
    start         = 1'b1;
    step();
    t_start       = cyc;
    start         = 1'b0;
    reload_params = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit bp);
    int d0;
    bit got;
    d0 = n_done;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      if (bp) begin
        fifo_almost_full = ($urandom_range(0, 2) == 0);
        fifo_rd_en       = !(i >= 6 && i < 11);
      end
      step();
      if (n_done > d0) begin
        got = 1;
        break;
      end
    end
    fifo_almost_full = 1'b0;
    fifo_rd_en       = 1'b1;
    check("done_seen", got, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {busy, done, i_valid, weight_wr_en, prm_rd_en, pix_rd_en}, '0);
    check({tag, "_wr"}, {weight_wr_addr, weight_wr_data}, '0);
    check({tag, "_misc"}, {prm_rd_addr, pix_rd_addr, frame_idx, i_data}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int   prm_bad, wr_bad, d_abort;
  logic [2:0] gap_idle;
  logic stream_rd;

  initial begin
    for (int k = 0; k < (1 << PRM_AW); k++) prm_mem[k] = 32'(k);
    prm_mem[431] = 32'h80;
    prm_mem[448] = 32'hAB;
    for (int i = 0; i < PIXELS; i++)
      pix_mem[i] = {8'(i), 8'(8'hA5 ^ 8'(i * 7)), 8'(i * 13 + 1)};

    rst_n = 1'b0; start = 1'b0; reload_params = 1'b0; abort = 1'b0;
    num_frames = 8'd1; fifo_rd_en = 1'b1; fifo_almost_full = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Parameter load followed by one frame.
    start_run(1'b1, 8'd1);
    prm_bad = 0; wr_bad = 0; gap_idle = '0; stream_rd = 1'b0;
    for (int c = 1; c <= NUM_PARAMS + 3; c++) begin
      @(negedge clk);
      if (prm_rd_en !== (c <= NUM_PARAMS)) prm_bad++;
      if (c <= NUM_PARAMS + 2 && weight_wr_en !== (c >= 2 && c <= NUM_PARAMS + 1)) wr_bad++;
      if (c == NUM_PARAMS + 2) gap_idle = {weight_wr_en, pix_rd_en, busy};
      if (c == NUM_PARAMS + 3) stream_rd = pix_rd_en;
    end
    check("prm_rd_window", prm_bad, 0);
    check("wr_window", wr_bad, 0);
    check("gap_idle_cycle", gap_idle, 3'b001);
    check("stream_first_rd", stream_rd, 1);
    wait_done(200, 1'b0);
    check("wr_count", n_wr, NUM_PARAMS);
    check("wr_word5", wr_seen[5], 32'h0000_0005);
    check("wr_word431", wr_seen[431], 32'hFFFF_FF80);
    check("wr_word448", wr_seen[448], 32'h0000_00AB);
    check("load_pix_count", n_pulse, PIXELS);

    // Full-rate single frame.
    start_run(1'b0, 8'd1);
    wait_done(100, 1'b0);
    check("full_pix_count", n_pulse, PIXELS);
    check("first_pix_latency", t_first - t_start, 3);
    check("full_rate_span", t_last - t_first, PIXELS - 1);

    // Backpressure.
    start_run(1'b0, 8'd1);
    wait_done(500, 1'b1);
    check("bp_pix_count", n_pulse, PIXELS);
    check("bp_queue_empty", pq.size(), 0);

    // Three frames.
    start_run(1'b0, 8'd3);
    wait_done(300, 1'b0);
    check("multi_pix_count", n_pulse, 3 * PIXELS);
    check("multi_max_frame", max_frame, 8'd2);
    check("multi_frame_hold", frame_idx, 8'd2);

    // start + abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1; reload_params = 1'b1;
    step();
    start = 1'b0; abort = 1'b0; reload_params = 1'b0;
    @(negedge clk);
    check("collide_idle", {busy, prm_rd_en, pix_rd_en}, 3'b000);
    check("collide_frame_kept", frame_idx, 8'd2);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("rst_clears_frame", frame_idx, 8'd0);
    rst_n = 1'b1;
    step();

    // num_frames == 0 behaves as one frame.
    start_run(1'b0, 8'd0);
    wait_done(100, 1'b0);
    check("zero_frames_count", n_pulse, PIXELS);

    // Abort mid-stream, then restart from pixel 0.
    start_run(1'b0, 8'd1);
    for (int i = 0; i < 50 && n_pulse < 8; i++) step();
    check("abort_reached_px7", n_pulse >= 8, 1);
    d_abort = n_done;
    abort = 1'b1;
    step();
    abort = 1'b0;
    pq.delete();
    exp_done = 0;
    @(negedge clk);
    check("abort_valid_low", i_valid, 0);
    check("abort_busy_low", busy, 0);
    repeat (5) step();
    check("abort_no_done", n_done, d_abort);
    start_run(1'b0, 8'd1);
    wait_done(100, 1'b0);
    check("restart_pix_count", n_pulse, PIXELS);

    // start during busy is ignored.
    start_run(1'b0, 8'd1);
    repeat (3) step();
    reload_params = 1'b1; start = 1'b1;
    step();
    start = 1'b0; reload_params = 1'b0;
    @(negedge clk);
    check("busy_start_no_load", prm_rd_en, 0);
    check("busy_start_busy", busy, 1);
    wait_done(100, 1'b0);
    check("busy_start_count", n_pulse, PIXELS);

    // Reset in the middle of LOAD.
    start_run(1'b1, 8'd1);
    repeat (10) step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check_all_zero("rst_in_load");
    rst_n = 1'b1;
    wq.delete();
    pq.delete();
    exp_done = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/model_stream_driver.md
# model_stream_driver

Synthesizable driver that feeds the conv `model` from on-chip memories, replacing hand-written bench sequencing.

- **Phase 1:** streams a parameter image (kernels, biases, MACC coefficient) from a parameter ROM onto the model's weight write port.
- **Phase 2:** streams one or more input frames from a pixel memory onto `i_data`/`i_valid`, honouring `fifo_rd_en` and `fifo_almost_full`.

It sits between the memory/host controller and `model`, and adds multi-frame streaming, optional parameter reload, and abort.

## Interface
- `IN_CHANNEL`, 3: channels per pixel; `i_data` width is 8*`IN_CHANNEL`.
- `PIXELS`, 65536: pixels per frame.
- `NUM_PARAMS`, 449: parameter words per image (432 kernel + 16 bias + 1 coeff).
- `KERNEL_WORDS`, 432: leading words that carry an 8-bit kernel value in bits 7:0.
- `PARAM_BASE`, 0: first `weight_wr_addr`.
- `PIX_AW`, 16: pixel memory address width; requires 2^`PIX_AW` ≥ `PIXELS`.
- `PRM_AW`, 10: parameter memory address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request; ignored while `busy`.
- `reload_params` in 1: sampled with `start`. 1 = run the parameter phase; 0 = skip it.
- `num_frames` in 8: sampled with `start`; 0 is treated as 1.
- `abort` in 1: return to IDLE.
- `prm_rd_en` out 1, `prm_rd_addr` out `PRM_AW`, `prm_rd_data` in 32: read data arrives 1 cycle after `prm_rd_en`.
- `pix_rd_en` out 1, `pix_rd_addr` out `PIX_AW`, `pix_rd_data` in 8*`IN_CHANNEL`: read data arrives 1 cycle after `pix_rd_en`.
- `weight_wr_en` out 1, `weight_wr_addr` out 32, `weight_wr_data` out 32.
- `i_data` out 8*`IN_CHANNEL`, `i_valid` out 1: channel 0 in the MSBs.
- `fifo_rd_en` in 1, `fifo_almost_full` in 1: downstream accept permission.
- `busy` out 1, `done` out 1 (one-cycle pulse), `frame_idx` out 8.

## Operation
- **States:** IDLE, LOAD, GAP, STREAM, FIN.
- **IDLE → LOAD** on `start && reload_params`; **IDLE → STREAM** on `start && !reload_params`.
- **LOAD:**
  - Issues `prm_rd_en` with addr k = 0..`NUM_PARAMS`-1, one per cycle.
  - One cycle later drives `weight_wr_en`=1, `weight_wr_addr`=`PARAM_BASE`+k.
  - `weight_wr_data`: sign-extended `prm_rd_data`[7:0] for k<`KERNEL_WORDS`, otherwise `prm_rd_data`[31:0] unchanged.
  - Enters GAP after the last read.
- **GAP:**
  - Lasts 2 cycles: the last write, then one idle cycle with `weight_wr_en`=0.
  - Then → STREAM.
- **STREAM:**
  - A 2-entry prefetch FIFO is filled from pixel memory.
  - A read is issued when occupancy + in-flight reads < 2 and pixels remain to fetch.
  - Per cycle, if `fifo_rd_en && !fifo_almost_full` and the FIFO is non-empty: pop; next edge `i_valid`=1 with the popped data. Otherwise `i_valid`=0.
  - One `i_valid` pulse equals one pixel; no pixel is duplicated or dropped.
- **Frames:**
  - The pixel address wraps `PIXELS`-1 → 0.
  - `frame_idx` increments when the last pixel of a frame is popped.
  - Prefetch continues across the frame boundary without a bubble.
  - After pixel `PIXELS`-1 of frame `num_frames`-1 is popped → FIN.
- **FIN:** one cycle, `done`=1, then → IDLE.
- **abort** (any state):
  - Next edge: IDLE, prefetch flushed, `i_valid`/`weight_wr_en`/`prm_rd_en`/`pix_rd_en`=0.
  - In-flight read data is discarded.
  - No `done` pulse.
- **`start` during `busy`:** ignored. `abort` and `start` in the same cycle: `abort` wins.
- **`busy`:** 1 in every state except IDLE.

## Timing
- **Reset values** (all outputs): 0; state IDLE; `frame_idx` 0.
- **Reset mid-operation** behaves as `abort`, and also clears `frame_idx`.
- **Parameter phase:** `start` sampled at edge 0; `prm_rd_en` high in cycles 1..`NUM_PARAMS`; `weight_wr_en` high in cycles 2..`NUM_PARAMS`+1, contiguous.
- **First pixel:** earliest first `i_valid` is 3 cycles after STREAM entry (read, FIFO write, pop).
- **Throughput:** 1 pixel/cycle while `fifo_rd_en && !fifo_almost_full` stays high.
- **Backpressure:** `fifo_almost_full` or `!fifo_rd_en` sampled high at edge n → `i_valid`=0 after edge n. Prefetch holds at 2 entries.
- **`done`:** asserted the cycle after the final `i_valid`.

## Structure
- Package `model_stream_pkg`:
  - state enum;
  - `KERNEL_BYTE_MSB`=7;
  - `WORD_W`=32;
  - function `sext8_to_32`.
- Sub-module `pix_prefetch_fifo`: 2-entry, parametrised width, with push, pop, count and flush.
- Top level: FSM, parameter counter, pixel counter, frame counter.

## Test plan
- **Parameter load:** `reload_params`=1, ROM[k]=k, `NUM_PARAMS`=449 → 449 writes at addr 0..448; word 5 → 0x00000005; ROM[431]=0x80 → 0xFFFFFF80; word 448=0xAB unchanged; exactly one idle cycle before STREAM.
- **Full-rate stream:** `PIXELS`=16, `reload_params`=0, `fifo_rd_en`=1, `fifo_almost_full`=0 → 16 consecutive `i_valid` pulses with data = mem[0..15] in order; `done` the cycle after the 16th pulse.
- **Backpressure:** toggle `fifo_almost_full` pseudo-randomly and drop `fifo_rd_en` for 5 cycles → `i_valid` never high the cycle after a blocked sample; 16 pixels delivered, in order, with no duplicates.
- **Multi-frame:** `num_frames`=3, `PIXELS`=16 → 48 pulses, address wraps, `frame_idx` reaches 2; `num_frames`=0 → 16 pulses.
- **Abort mid-stream:** abort after pixel 7 → `i_valid`=0 and `busy`=0 next cycle, no `done`; a new `start` restarts at pixel 0.
- **Start/reset collisions:** `start` during `busy` is ignored; `rst_n`=0 during LOAD zeroes all outputs at the next edge; simultaneous `start`+`abort` in IDLE stays IDLE.
